// File: rtl/gate_reduce_unit_if.sv
// Streaming bus for gate_reduce_unit: input word handshake, result handshake and status flags.
// Latency: none; this is a plain signal bundle.
// Backpressure: in_ready/out_ready carry the valid-ready flow control in each direction.
// Ports (via modports):
//   slave (the reduce unit): op, in_valid, a, out_ready in; in_ready, out_valid, c, op_err, busy out
//   master (producer/consumer side): the mirror image
//   parity (slave out) exists only when GATE_REDUCE_PARITY_EN is defined
interface gate_reduce_unit_if #(
  parameter int WIDTH = 8
);
  logic [2:0]       op;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] c;
  logic             op_err;
  logic             busy;
`ifdef GATE_REDUCE_PARITY_EN
  logic             parity;

  modport slave (
    input  op, in_valid, a, out_ready,
    output in_ready, out_valid, c, op_err, busy, parity
  );

  modport master (
    output op, in_valid, a, out_ready,
    input  in_ready, out_valid, c, op_err, busy, parity
  );
`else
  modport slave (
    input  op, in_valid, a, out_ready,
    output in_ready, out_valid, c, op_err, busy
  );

  modport master (
    output op, in_valid, a, out_ready,
    input  in_ready, out_valid, c, op_err, busy
  );
`endif
endinterface

// File: rtl/gate_reduce_unit.sv
// Folds a frame of COUNT words through one bitwise gate (AND/OR/XOR, optionally inverted at the end).
// Latency: out_valid rises on the edge that accepts the last word; at most one frame per COUNT+1 cycles.
// Backpressure: in_ready drops while a result waits; the result holds until out_ready is seen.
// Ports: clk, rst_n (async active-low); bus (gate_reduce_unit_if.slave) carries op/in_valid/in_ready/a,
//   out_valid/out_ready/c, op_err, busy. Optional macro GATE_REDUCE_PARITY_EN adds bus.parity = ^c.
module gate_reduce_unit #(
  parameter int WIDTH = 8,
  parameter int COUNT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  gate_reduce_unit_if.slave   bus
);

  localparam int            CW   = $clog2(COUNT + 1);
  localparam logic [CW-1:0] LAST = CW'(COUNT);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  typedef enum logic [1:0] {B_AND, B_OR, B_XOR} base_t;

  state_t           r_state;
  state_t           w_state_nxt;
  base_t            r_base;
  logic             r_inv;
  logic             r_op_err;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_c;
  logic [CW-1:0]    r_cnt;

  base_t            w_in_base;
  logic             w_in_inv;
  logic             w_in_err;
  logic             w_in_rdy;
  logic             w_in_xfer;
  logic             w_out_xfer;
  logic [WIDTH-1:0] w_fold;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             w_last;
  logic             w_inv;
  logic [WIDTH-1:0] w_res;

  // Decode the incoming op; only used on the first word of a frame.
  // Reserved codes fall back to plain AND and flag an error.
  always_comb begin
    w_in_base = B_AND;
    w_in_inv  = 1'b0;
    w_in_err  = 1'b0;
    case (bus.op)
      3'b001: w_in_base = B_OR;
      3'b010: w_in_base = B_XOR;
      3'b011: w_in_inv  = 1'b1;
      3'b100: begin w_in_base = B_OR;  w_in_inv = 1'b1; end
      3'b101: begin w_in_base = B_XOR; w_in_inv = 1'b1; end
      3'b110, 3'b111: w_in_err = 1'b1;
      default: ;
    endcase
  end

  // Ready/valid depend on registered state only, so no input-to-output combinational path.
  assign w_in_rdy   = (r_state != DONE);
  assign w_in_xfer  = bus.in_valid && w_in_rdy;
  assign w_out_xfer = (r_state == DONE) && bus.out_ready;

  always_comb begin
    case (r_base)
      B_OR:    w_fold = r_acc | bus.a;
      B_XOR:   w_fold = r_acc ^ bus.a;
      default: w_fold = r_acc & bus.a;
    endcase
  end

  // First word seeds the accumulator; later words fold into it.
  assign w_acc_nxt = (r_state == IDLE) ? bus.a : w_fold;
  assign w_cnt_nxt = (r_state == IDLE) ? CW'(1) : r_cnt + CW'(1);
  assign w_last    = (w_cnt_nxt == LAST);
  // For COUNT==1 the frame finishes in IDLE, before the latched invert exists.
  assign w_inv     = (r_state == IDLE) ? w_in_inv : r_inv;
  // Inversion applies once to the finished fold, never per step.
  assign w_res     = w_inv ? ~w_acc_nxt : w_acc_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, ACCUM: if (w_in_xfer) w_state_nxt = w_last ? DONE : ACCUM;
      DONE:        if (w_out_xfer) w_state_nxt = IDLE;
      default:     w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_cnt    <= '0;
      r_c      <= '0;
      r_base   <= B_AND;
      r_inv    <= 1'b0;
      r_op_err <= 1'b0;
    end else if (w_in_xfer) begin
      r_acc <= w_acc_nxt;
      r_cnt <= w_cnt_nxt;
      if (r_state == IDLE) begin
        r_base   <= w_in_base;
        r_inv    <= w_in_inv;
        r_op_err <= w_in_err;
      end
      if (w_last) r_c <= w_res;
    end else if (w_out_xfer) begin
      r_cnt <= '0;
    end
  end

`ifdef GATE_REDUCE_PARITY_EN
  logic r_parity;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  r_parity <= 1'b0;
    else if (w_in_xfer && w_last) r_parity <= ^w_res;
  end

  assign bus.parity = r_parity;
`endif

  assign bus.in_ready  = w_in_rdy;
  assign bus.out_valid = (r_state == DONE);
  assign bus.busy      = (r_state != IDLE);
  assign bus.c         = r_c;
  assign bus.op_err    = r_op_err;

endmodule

// File: tb/tb_gate_reduce_unit.sv
module tb_gate_reduce_unit;

  typedef logic [7:0] word_t;
  typedef word_t frame_t [4];

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   chk_cnt  = 0;
  int   pass_cnt = 0;

  gate_reduce_unit_if #(.WIDTH(8)) u_if ();
  gate_reduce_unit_if #(.WIDTH(8)) u_if1 ();

  gate_reduce_unit #(.WIDTH(8), .COUNT(4)) u_dut (.clk(clk), .rst_n(rst_n), .bus(u_if.slave));
  gate_reduce_unit #(.WIDTH(8), .COUNT(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(u_if1.slave));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, pass=%0d total=%0d", pass_cnt, chk_cnt);
    $fatal(1);
  end

  // Reference: fold the first n words with the gate named by op, invert the end result for
  // NAND/NOR/XNOR; reserved codes behave as AND and raise the error bit (bit 8).
  function automatic logic [8:0] model(input logic [2:0] op, input frame_t w, input int n);
    logic [7:0] r;
    r = w[0];
    for (int i = 1; i < n; i++) begin
      case (op)
        3'd1, 3'd4: r = r | w[i];
        3'd2, 3'd5: r = r ^ w[i];
        default:    r = r & w[i];
      endcase
    end
    if (op == 3'd3 || op == 3'd4 || op == 3'd5) r = ~r;
    return {op[2] & op[1], r};
  endfunction

  // Present four words; op is scrambled after the first word to prove it is ignored.
  // Returns with time just past the edge that accepted the last word.
  task automatic feed_frame(input logic [2:0] op, input frame_t w, input int gap, output bit to);
    int n;
    to = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      u_if.in_valid = 1'b1;
      u_if.a        = w[i];
      u_if.op       = (i == 0) ? op : 3'($urandom);
      n = 0;
      while (!u_if.in_ready && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (n >= 20) to = 1'b1;
      @(posedge clk);
      if (i < 3) begin
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          u_if.in_valid = 1'b0;
          @(posedge clk);
        end
      end
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    chk_cnt++; if (u_if.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", u_if.out_valid); else pass_cnt++;
    chk_cnt++; if (u_if.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", u_if.busy); else pass_cnt++;
    chk_cnt++; if (u_if.c !== 8'h00) $display("FAIL reset_c: got %h want 00", u_if.c); else pass_cnt++;
    chk_cnt++; if (u_if.op_err !== 1'b0) $display("FAIL reset_op_err: got %b want 0", u_if.op_err); else pass_cnt++;
`ifdef GATE_REDUCE_PARITY_EN
    chk_cnt++; if (u_if.parity !== 1'b0) $display("FAIL reset_parity: got %b want 0", u_if.parity); else pass_cnt++;
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_cnt++; if (u_if.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", u_if.in_ready); else pass_cnt++;
    chk_cnt++; if (u_if1.in_ready !== 1'b1) $display("FAIL reset_in_ready1: got %b want 1", u_if1.in_ready); else pass_cnt++;
  endtask

  task automatic test_and_frame();
    frame_t f;
    bit     to;
    f = '{8'hFF, 8'hF0, 8'h3C, 8'hFF};
    u_if.out_ready = 1'b1;
    feed_frame(3'b000, f, 0, to);
    chk_cnt++; if (to) $display("FAIL and_timeout: in_ready never rose"); else pass_cnt++;
    @(negedge clk);
    u_if.in_valid = 1'b0;
    chk_cnt++; if (u_if.out_valid !== 1'b1) $display("FAIL and_out_valid: got %b want 1", u_if.out_valid); else pass_cnt++;
    chk_cnt++; if (u_if.c !== 8'h30) $display("FAIL and_c: got %h want 30", u_if.c); else pass_cnt++;
    chk_cnt++; if (u_if.op_err !== 1'b0) $display("FAIL and_op_err: got %b want 0", u_if.op_err); else pass_cnt++;
    chk_cnt++; if (u_if.in_ready !== 1'b0) $display("FAIL and_in_ready_done: got %b want 0", u_if.in_ready); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (u_if.out_valid !== 1'b0) $display("FAIL and_out_valid_pulse: got %b want 0", u_if.out_valid); else pass_cnt++;
    chk_cnt++; if (u_if.busy !== 1'b0) $display("FAIL and_busy_after: got %b want 0", u_if.busy); else pass_cnt++;
  endtask

  task automatic test_xnor_gaps();
    frame_t f;
    f = '{8'h0F, 8'h0F, 8'hF0, 8'h00};
    u_if.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      u_if.in_valid = 1'b1;
      u_if.a        = f[i];
      u_if.op       = (i == 0) ? 3'b101 : 3'($urandom);
      @(posedge clk);
      if (i < 3) begin
        for (int g = 0; g < 2; g++) begin
          @(negedge clk);
          u_if.in_valid = 1'b0;
          u_if.a        = 8'($urandom);
          chk_cnt++; if (u_if.busy !== 1'b1) $display("FAIL xnor_busy_gap: word %0d got %b want 1", i, u_if.busy); else pass_cnt++;
          @(posedge clk);
        end
      end
    end
    @(negedge clk);
    u_if.in_valid = 1'b0;
    chk_cnt++; if (u_if.out_valid !== 1'b1) $display("FAIL xnor_out_valid: got %b want 1", u_if.out_valid); else pass_cnt++;
    chk_cnt++; if (u_if.c !== 8'h0F) $display("FAIL xnor_c: got %h want 0f", u_if.c); else pass_cnt++;
    chk_cnt++; if (u_if.busy !== 1'b1) $display("FAIL xnor_busy_done: got %b want 1", u_if.busy); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (u_if.busy !== 1'b0) $display("FAIL xnor_busy_after: got %b want 0", u_if.busy); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    frame_t f;
    bit     to;
    f = '{8'h01, 8'h02, 8'h04, 8'h08};
    u_if.out_ready = 1'b0;
    feed_frame(3'b001, f, 0, to);
    chk_cnt++; if (to) $display("FAIL bp_timeout: in_ready never rose"); else pass_cnt++;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      u_if.in_valid = 1'b1;
      u_if.a        = 8'hFF;
      chk_cnt++; if (u_if.out_valid !== 1'b1) $display("FAIL bp_out_valid: cycle %0d got %b want 1", k, u_if.out_valid); else pass_cnt++;
      chk_cnt++; if (u_if.c !== 8'h0F) $display("FAIL bp_c_stable: cycle %0d got %h want 0f", k, u_if.c); else pass_cnt++;
      chk_cnt++; if (u_if.in_ready !== 1'b0) $display("FAIL bp_in_ready: cycle %0d got %b want 0", k, u_if.in_ready); else pass_cnt++;
    end
    @(negedge clk);
    u_if.out_ready = 1'b1;
    u_if.in_valid  = 1'b0;
    @(negedge clk);
    chk_cnt++; if (u_if.out_valid !== 1'b0) $display("FAIL bp_released: got %b want 0", u_if.out_valid); else pass_cnt++;
    chk_cnt++; if (u_if.busy !== 1'b0) $display("FAIL bp_no_consume: busy got %b want 0", u_if.busy); else pass_cnt++;
    chk_cnt++; if (u_if.c !== 8'h0F) $display("FAIL bp_c_kept: got %h want 0f", u_if.c); else pass_cnt++;
  endtask

  task automatic test_reset_mid_frame();
    frame_t f;
    bit     to;
    u_if.out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      u_if.in_valid = 1'b1;
      u_if.a        = 8'($urandom);
      u_if.op       = 3'($urandom);
      @(posedge clk);
    end
    #2;
    u_if.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_cnt++; if (u_if.busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", u_if.busy); else pass_cnt++;
    chk_cnt++; if (u_if.out_valid !== 1'b0) $display("FAIL midrst_out_valid: got %b want 0", u_if.out_valid); else pass_cnt++;
    chk_cnt++; if (u_if.c !== 8'h00) $display("FAIL midrst_c: got %h want 00", u_if.c); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    f = '{8'h00, 8'h00, 8'h00, 8'h01};
    feed_frame(3'b100, f, 0, to);
    chk_cnt++; if (to) $display("FAIL midrst_timeout: in_ready never rose"); else pass_cnt++;
    @(negedge clk);
    u_if.in_valid = 1'b0;
    chk_cnt++; if (u_if.out_valid !== 1'b1) $display("FAIL midrst_nor_valid: got %b want 1", u_if.out_valid); else pass_cnt++;
    chk_cnt++; if (u_if.c !== 8'hFE) $display("FAIL midrst_nor_c: got %h want fe", u_if.c); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_reserved_op();
    frame_t     f;
    bit         to;
    logic [8:0] exp;
    u_if.out_ready = 1'b1;
    f = '{8'hFF, 8'h0F, 8'hFF, 8'hFF};
    feed_frame(3'b110, f, 0, to);
    @(negedge clk);
    u_if.in_valid = 1'b0;
    chk_cnt++; if (u_if.c !== 8'h0F) $display("FAIL rsv_c: got %h want 0f", u_if.c); else pass_cnt++;
    chk_cnt++; if (u_if.op_err !== 1'b1) $display("FAIL rsv_op_err: got %b want 1", u_if.op_err); else pass_cnt++;
    @(negedge clk);
    for (int i = 0; i < 4; i++) f[i] = 8'($urandom);
    exp = model(3'b001, f, 4);
    feed_frame(3'b001, f, 0, to);
    @(negedge clk);
    u_if.in_valid = 1'b0;
    chk_cnt++; if (u_if.op_err !== exp[8]) $display("FAIL rsv_next_op_err: got %b want %b", u_if.op_err, exp[8]); else pass_cnt++;
    chk_cnt++; if (u_if.c !== exp[7:0]) $display("FAIL rsv_next_c: got %h want %h", u_if.c, exp[7:0]); else pass_cnt++;
    @(negedge clk);
  endtask

  // in_valid stays high across frame boundaries; the word offered during the result cycle must not count.
  task automatic test_back_to_back();
    frame_t     f;
    bit         to;
    logic [2:0] op;
    logic [8:0] exp;
    u_if.out_ready = 1'b1;
    for (int fr = 0; fr < 3; fr++) begin
      op = 3'($urandom_range(0, 5));
      for (int i = 0; i < 4; i++) f[i] = 8'($urandom);
      exp = model(op, f, 4);
      feed_frame(op, f, 0, to);
      chk_cnt++; if (to) $display("FAIL b2b_timeout: frame %0d", fr); else pass_cnt++;
      @(negedge clk);
      u_if.a = 8'($urandom);
      chk_cnt++; if (u_if.in_ready !== 1'b0) $display("FAIL b2b_in_ready: frame %0d got %b want 0", fr, u_if.in_ready); else pass_cnt++;
      chk_cnt++; if (u_if.c !== exp[7:0]) $display("FAIL b2b_c: frame %0d op %0d got %h want %h", fr, op, u_if.c, exp[7:0]); else pass_cnt++;
    end
    @(negedge clk);
    u_if.in_valid = 1'b0;
  endtask

  task automatic test_random();
    frame_t     f;
    bit         to;
    logic [2:0] op;
    logic [8:0] exp;
    int         d;
    for (int fr = 0; fr < 20; fr++) begin
      op = 3'($urandom_range(0, 7));
      for (int i = 0; i < 4; i++) f[i] = 8'($urandom);
      exp = model(op, f, 4);
      d = $urandom_range(0, 3);
      u_if.out_ready = 1'b0;
      feed_frame(op, f, $urandom_range(0, 2), to);
      chk_cnt++; if (to) $display("FAIL rnd_timeout: frame %0d", fr); else pass_cnt++;
      @(negedge clk);
      u_if.in_valid = 1'b0;
      chk_cnt++; if (u_if.out_valid !== 1'b1) $display("FAIL rnd_out_valid: frame %0d got %b want 1", fr, u_if.out_valid); else pass_cnt++;
      chk_cnt++; if (u_if.c !== exp[7:0]) $display("FAIL rnd_c: frame %0d op %0d got %h want %h", fr, op, u_if.c, exp[7:0]); else pass_cnt++;
      chk_cnt++; if (u_if.op_err !== exp[8]) $display("FAIL rnd_op_err: frame %0d op %0d got %b want %b", fr, op, u_if.op_err, exp[8]); else pass_cnt++;
`ifdef GATE_REDUCE_PARITY_EN
      chk_cnt++; if (u_if.parity !== ^exp[7:0]) $display("FAIL rnd_parity: frame %0d got %b want %b", fr, u_if.parity, ^exp[7:0]); else pass_cnt++;
`endif
      for (int k = 0; k < d; k++) begin
        @(negedge clk);
        chk_cnt++; if (u_if.c !== exp[7:0] || u_if.out_valid !== 1'b1) $display("FAIL rnd_hold: frame %0d c %h valid %b want %h 1", fr, u_if.c, u_if.out_valid, exp[7:0]); else pass_cnt++;
      end
      u_if.out_ready = 1'b1;
      @(negedge clk);
      chk_cnt++; if (u_if.out_valid !== 1'b0) $display("FAIL rnd_drain: frame %0d got %b want 0", fr, u_if.out_valid); else pass_cnt++;
    end
  endtask

  task automatic test_count1();
    frame_t     f;
    logic [2:0] op;
    logic [8:0] exp;
    for (int fr = 0; fr < 3; fr++) begin
      op = (fr == 0) ? 3'b011 : 3'($urandom);
      f[0] = (fr == 0) ? 8'hA5 : 8'($urandom);
      exp = model(op, f, 1);
      @(negedge clk);
      u_if1.out_ready = 1'b0;
      u_if1.in_valid  = 1'b1;
      u_if1.op        = op;
      u_if1.a         = f[0];
      @(negedge clk);
      u_if1.in_valid = 1'b0;
      chk_cnt++; if (u_if1.out_valid !== 1'b1) $display("FAIL c1_out_valid: frame %0d got %b want 1", fr, u_if1.out_valid); else pass_cnt++;
      chk_cnt++; if (u_if1.c !== exp[7:0]) $display("FAIL c1_c: frame %0d op %0d got %h want %h", fr, op, u_if1.c, exp[7:0]); else pass_cnt++;
      chk_cnt++; if (u_if1.op_err !== exp[8]) $display("FAIL c1_op_err: frame %0d got %b want %b", fr, u_if1.op_err, exp[8]); else pass_cnt++;
`ifdef GATE_REDUCE_PARITY_EN
      chk_cnt++; if (u_if1.parity !== ^exp[7:0]) $display("FAIL c1_parity: frame %0d got %b want %b", fr, u_if1.parity, ^exp[7:0]); else pass_cnt++;
`endif
      u_if1.out_ready = 1'b1;
      @(negedge clk);
      chk_cnt++; if (u_if1.out_valid !== 1'b0) $display("FAIL c1_drain: frame %0d got %b want 0", fr, u_if1.out_valid); else pass_cnt++;
    end
  endtask

  initial begin
    u_if.op         = 3'b000;
    u_if.in_valid   = 1'b0;
    u_if.a          = 8'h00;
    u_if.out_ready  = 1'b0;
    u_if1.op        = 3'b000;
    u_if1.in_valid  = 1'b0;
    u_if1.a         = 8'h00;
    u_if1.out_ready = 1'b0;
    test_reset();
    test_and_frame();
    test_xnor_gaps();
    test_backpressure();
    test_reset_mid_frame();
    test_reserved_op();
    test_back_to_back();
    test_random();
    test_count1();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
